// File: rtl/dac_spi_out.sv
// dac_spi_out: scales each oscillator sample by a 5-bit volume and shifts it out as a 16-bit MSB-first SPI frame.
// Latency: CS_N falls 2 cycles after sample_valid. No backpressure: a full one-entry hold is overwritten and overrun pulses.
module dac_spi_out #(
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sample_in,
  input  logic        sample_valid,
  input  logic [4:0]  vol,
  output logic        DAC_SCLK,
  output logic        DAC_SDI,
  output logic        DAC_CS_N,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  state_t      state, state_n;
  logic [15:0] hold_data;
  logic [4:0]  hold_vol;
  logic        hold_full;
  logic        pull;
  logic [20:0] product;
  logic [15:0] scaled;
  logic [15:0] shreg, shreg_n;
  logic [3:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  div_cnt, div_cnt_n;
  logic [7:0]  gap_cnt, gap_cnt_n;
  logic        sclk_n, sdi_n, cs_n_n;

  // Truncating scale: keep the top 16 of the 21-bit product.
  assign product = {5'd0, hold_data} * {16'd0, hold_vol};
  assign scaled  = 16'(product >> 5);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_data <= '0;
      hold_vol  <= '0;
      hold_full <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (sample_valid) begin
        hold_data <= sample_in;
        hold_vol  <= vol;
        hold_full <= 1'b1;
      end else if (pull) begin
        hold_full <= 1'b0;
      end
      overrun <= sample_valid && hold_full && !pull;
      busy    <= sample_valid || hold_full || (state != IDLE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
      gap_cnt  <= '0;
      DAC_SCLK <= 1'b0;
      DAC_SDI  <= 1'b0;
      DAC_CS_N <= 1'b1;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      bit_cnt  <= bit_cnt_n;
      div_cnt  <= div_cnt_n;
      gap_cnt  <= gap_cnt_n;
      DAC_SCLK <= sclk_n;
      DAC_SDI  <= sdi_n;
      DAC_CS_N <= cs_n_n;
    end
  end

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    div_cnt_n = div_cnt;
    gap_cnt_n = gap_cnt;
    sclk_n    = DAC_SCLK;
    sdi_n     = DAC_SDI;
    cs_n_n    = DAC_CS_N;
    pull      = 1'b0;
    case (state)
      IDLE: begin
        if (hold_full) begin
          pull      = 1'b1;
          shreg_n   = scaled;
          bit_cnt_n = 4'd15;
          div_cnt_n = '0;
          sclk_n    = 1'b0;
          sdi_n     = scaled[15];
          cs_n_n    = 1'b0;
          state_n   = SHIFT;
        end
      end
      SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_n = '0;
          if (!DAC_SCLK) begin
            sclk_n = 1'b1;
          end else begin
            sclk_n = 1'b0;
            // The last falling edge closes the frame instead of shifting.
            if (bit_cnt == 4'd0) begin
              state_n   = GAP;
              cs_n_n    = 1'b1;
              sdi_n     = 1'b0;
              gap_cnt_n = '0;
            end else begin
              shreg_n   = {shreg[14:0], 1'b0};
              sdi_n     = shreg[14];
              bit_cnt_n = bit_cnt - 4'd1;
            end
          end
        end else begin
          div_cnt_n = div_cnt + 8'd1;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_n = IDLE;
        end else begin
          gap_cnt_n = gap_cnt + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dac_spi_out.sv
// Bench for dac_spi_out: per-cycle comparison against a timeline model, frame decoding, and directed literal checks.
module tb_dac_spi_out;

  localparam int D     = 2;
  localparam int G     = 2;
  localparam int FRAME = 32 * D;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] s_in, s2_in;
  logic        s_vld, s2_vld;
  logic [4:0]  s_vol, s2_vol;
  logic sclk0, sdi0, cs0, busy0, ovr0;
  logic sclk1, sdi1, cs1, busy1, ovr1;

  dac_spi_out u_dut (
    .clk(clk), .rst(rst), .sample_in(s_in), .sample_valid(s_vld), .vol(s_vol),
    .DAC_SCLK(sclk0), .DAC_SDI(sdi0), .DAC_CS_N(cs0), .busy(busy0), .overrun(ovr0)
  );

  dac_spi_out #(.CLK_DIV(1), .GAP_CYCLES(1)) u_dut2 (
    .clk(clk), .rst(rst), .sample_in(s2_in), .sample_valid(s2_vld), .vol(s2_vol),
    .DAC_SCLK(sclk1), .DAC_SDI(sdi1), .DAC_CS_N(cs1), .busy(busy1), .overrun(ovr1)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  function automatic int scale(input int s, input int v);
    return (s * v) >> 5;
  endfunction

  // Timeline model: a frame loaded on edge L drives CS low for the FRAME
  // registered cycles after it; the line is ready again FRAME+G+1 edges later.
  int   ecnt = 0;
  bit   have_l, pend, m_pull;
  int   l_edge, pend_val, cur_val, m_k;
  logic e_cs, e_sclk, e_sdi, e_busy, e_ovr;

  initial forever begin
    @(posedge clk);
    ecnt++;
    if (rst) begin
      have_l = 0; pend = 0;
      e_cs = 1; e_sclk = 0; e_sdi = 0; e_busy = 0; e_ovr = 0;
    end else begin
      m_pull = pend && (!have_l || ecnt >= l_edge + 1 + FRAME + G);
      e_ovr  = s_vld && pend && !m_pull;
      e_busy = s_vld || pend || (have_l && ecnt < l_edge + 1 + FRAME + G);
      if (m_pull) begin
        l_edge = ecnt; have_l = 1; cur_val = pend_val; pend = 0;
      end
      if (s_vld) begin
        pend = 1;
        pend_val = scale(int'(s_in), int'(s_vol));
      end
      m_k = ecnt - l_edge;
      if (have_l && m_k < FRAME) begin
        e_cs   = 0;
        e_sclk = ((m_k / D) % 2) == 1;
        e_sdi  = cur_val[15 - m_k / (2 * D)];
      end else begin
        e_cs = 1; e_sclk = 0; e_sdi = 0;
      end
    end
  end

  // Per-cycle compare of instance 0 plus frame decoding for both instances.
  logic [1:0] m_cs, m_sclk, m_sdi, m_busy, m_ovr;
  assign m_cs   = {cs1, cs0};
  assign m_sclk = {sclk1, sclk0};
  assign m_sdi  = {sdi1, sdi0};
  assign m_busy = {busy1, busy0};
  assign m_ovr  = {ovr1, ovr0};

  logic [1:0]  p_cs = 2'b11, p_sclk = 2'b00, p_busy = 2'b00;
  logic [15:0] sh [2];
  int nrise [2], last_nrise [2], cs_fall_e [2], cs_rise_e [2];
  int busy_fall_e [2], ovr_cnt [2], ovr_e [2];
  logic [15:0] cap0 [$];
  logic [15:0] cap1 [$];

  initial forever begin
    @(negedge clk);
    if (rst) begin
      chk("rst_cs_n", int'(cs0), 1);
      chk("rst_sclk", int'(sclk0), 0);
      chk("rst_sdi", int'(sdi0), 0);
      chk("rst_busy", int'(busy0), 0);
      chk("rst_overrun", int'(ovr0), 0);
    end else begin
      chk("cyc_cs_n", int'(cs0), int'(e_cs));
      chk("cyc_sclk", int'(sclk0), int'(e_sclk));
      chk("cyc_sdi", int'(sdi0), int'(e_sdi));
      chk("cyc_busy", int'(busy0), int'(e_busy));
      chk("cyc_overrun", int'(ovr0), int'(e_ovr));
    end
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        nrise[i] = 0;
        sh[i] = '0;
      end else begin
        if (!m_cs[i] && m_sclk[i] && !p_sclk[i]) begin
          sh[i] = {sh[i][14:0], m_sdi[i]};
          nrise[i]++;
        end
        if (!m_cs[i] && p_cs[i]) cs_fall_e[i] = ecnt;
        if (m_cs[i] && !p_cs[i]) begin
          cs_rise_e[i]  = ecnt;
          last_nrise[i] = nrise[i];
          nrise[i] = 0;
          if (i == 0) cap0.push_back(sh[i]);
          else        cap1.push_back(sh[i]);
        end
        if (!m_busy[i] && p_busy[i]) busy_fall_e[i] = ecnt;
        if (m_ovr[i]) begin
          ovr_cnt[i]++;
          ovr_e[i] = ecnt;
        end
      end
    end
    p_cs = m_cs; p_sclk = m_sclk; p_busy = m_busy;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Called 2 time units after an edge; the next edge samples the strobe.
  task automatic send(input int inst, input logic [15:0] v, input logic [4:0] vl, output int e);
    if (inst == 0) begin s_in = v; s_vol = vl; s_vld = 1'b1; end
    else begin s2_in = v; s2_vol = vl; s2_vld = 1'b1; end
    @(posedge clk);
    #1 e = ecnt;
    #1;
    if (inst == 0) begin s_vld = 1'b0; s_vol = 5'($urandom); s_in = 16'($urandom); end
    else begin s2_vld = 1'b0; s2_vol = 5'($urandom); end
  endtask

  int e0, ed;
  logic [15:0] sc_in  [3] = '{16'h8000, 16'h1234, 16'h0001};
  logic [4:0]  sc_vol [3] = '{5'd31, 5'd0, 5'd31};
  logic [15:0] sc_exp [3] = '{16'h7C00, 16'h0000, 16'h0000};
  logic [15:0] v2 [3] = '{16'hBEEF, 16'h0F0F, 16'hFFFF};

  initial begin
    s_in = '0; s_vld = 1'b0; s_vol = '0;
    s2_in = '0; s2_vld = 1'b0; s2_vol = '0;
    ovr_cnt[0] = 0; ovr_cnt[1] = 0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    wait_cyc(3);

    // Single frame; edge offsets below are one less than the "cycle N" of the frame timing.
    cap0.delete();
    send(0, 16'hFFFF, 5'd16, e0);
    wait_cyc(75);
    chk("single_cs_fall", cs_fall_e[0] - e0, 1);
    chk("single_cs_rise", cs_rise_e[0] - e0, 65);
    chk("single_sclk_rises", last_nrise[0], 16);
    chk("single_nframes", cap0.size(), 1);
    chk("single_data", cap0.size() > 0 ? int'(cap0[0]) : -1, 16'h7FFF);
    chk("single_busy_fall", busy_fall_e[0] - e0, 68);

    for (int i = 0; i < 3; i++) begin
      cap0.delete();
      send(0, sc_in[i], sc_vol[i], e0);
      wait_cyc(75);
      chk("scale_data", cap0.size() > 0 ? int'(cap0[0]) : -1, int'(sc_exp[i]));
    end

    // Two samples 10 cycles apart: both sent, no overrun.
    cap0.delete(); ovr_cnt[0] = 0;
    send(0, 16'h1111, 5'd20, e0);
    wait_cyc(9);
    send(0, 16'h2222, 5'd20, ed);
    wait_cyc(150);
    chk("buf2_overrun", ovr_cnt[0], 0);
    chk("buf2_nframes", cap0.size(), 2);
    chk("buf2_a", cap0.size() > 0 ? int'(cap0[0]) : -1, scale(16'h1111, 20));
    chk("buf2_b", cap0.size() > 1 ? int'(cap0[1]) : -1, scale(16'h2222, 20));

    // Third sample overwrites the waiting one.
    cap0.delete(); ovr_cnt[0] = 0;
    send(0, 16'h1111, 5'd20, e0);
    wait_cyc(9);
    send(0, 16'h2222, 5'd20, ed);
    wait_cyc(9);
    send(0, 16'h3333, 5'd20, ed);
    wait_cyc(150);
    chk("buf3_overrun_cnt", ovr_cnt[0], 1);
    chk("buf3_overrun_edge", ovr_e[0] - e0, 20);
    chk("buf3_nframes", cap0.size(), 2);
    chk("buf3_a", cap0.size() > 0 ? int'(cap0[0]) : -1, scale(16'h1111, 20));
    chk("buf3_c", cap0.size() > 1 ? int'(cap0[1]) : -1, scale(16'h3333, 20));

    // Reset while bit 8 is on the wire.
    cap0.delete();
    send(0, 16'hAAAA, 5'd31, e0);
    wait_cyc(30);
    chk("midrst_in_frame", int'(cs0), 0);
    rst = 1'b1;
    #1;
    chk("midrst_cs_async", int'(cs0), 1);
    chk("midrst_sclk_async", int'(sclk0), 0);
    chk("midrst_busy_async", int'(busy0), 0);
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(3);
    chk("midrst_no_frame", cap0.size(), 0);
    send(0, 16'h00FF, 5'd31, e0);
    wait_cyc(75);
    chk("midrst_nframes", cap0.size(), 1);
    chk("midrst_data", cap0.size() > 0 ? int'(cap0[0]) : -1, 16'h00F7);

    // Random traffic, checked cycle by cycle against the model.
    repeat (40) begin
      send(0, 16'($urandom), 5'($urandom), ed);
      wait_cyc($urandom_range(0, 80));
    end
    wait_cyc(150);

    // Fast variant: 32-cycle frames, 34-cycle spacing is overrun-free.
    cap1.delete(); ovr_cnt[1] = 0;
    for (int i = 0; i < 3; i++) begin
      send(1, v2[i], 5'd29, ed);
      if (i < 2) wait_cyc(33);
    end
    wait_cyc(60);
    chk("fast_overrun", ovr_cnt[1], 0);
    chk("fast_cs_low", cs_rise_e[1] - cs_fall_e[1], 32);
    chk("fast_sclk_rises", last_nrise[1], 16);
    chk("fast_nframes", cap1.size(), 3);
    for (int i = 0; i < 3; i++)
      chk("fast_data", cap1.size() > i ? int'(cap1[i]) : -1, scale(int'(v2[i]), 29));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
